// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: datapath widths, fetch FSM states, IF/ID register layout.
package fetch_stage_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_READY
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instruction;
  } if_id_t;

  // Redirect targets are word aligned; the low two bits are forced to zero.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] target);
    return target & PC_ALIGN_MASK;
  endfunction

  // Sequential next PC; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] inc_pc(input logic [XLEN-1:0] cur);
    return cur + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem read, result registered into an IF/ID holding slot.
// Latency: data valid one cycle after the response; holds until id_valid pushes it, memory stalls via imem_req_ready.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        id_valid,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_data_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_instruction
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            squash, squash_nxt;
  logic            data_rdy, data_rdy_nxt;
  if_id_t          if_reg, if_reg_nxt;
  logic [XLEN-1:0] redirect_tgt;

  assign redirect_tgt = align_pc(redirect_pc);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      squash   <= 1'b0;
      data_rdy <= 1'b0;
      if_reg   <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      squash   <= squash_nxt;
      data_rdy <= data_rdy_nxt;
      if_reg   <= if_reg_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    squash_nxt   = squash;
    data_rdy_nxt = data_rdy;
    if_reg_nxt   = if_reg;

    unique case (state)
      ST_IDLE: begin
        state_nxt = ST_REQ;
        if (redirect_valid) begin
          pc_nxt = redirect_tgt;
        end
      end

      ST_REQ: begin
        // A redirect drops any acceptance seen this cycle and reissues at the new target.
        if (redirect_valid) begin
          pc_nxt = redirect_tgt;
        end else if (imem_req_ready) begin
          state_nxt = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redirect_valid) begin
          pc_nxt = redirect_tgt;
          if (imem_resp_valid) begin
            state_nxt  = ST_REQ;
            squash_nxt = 1'b0;
          end else begin
            squash_nxt = 1'b1;
          end
        end else if (imem_resp_valid) begin
          squash_nxt = 1'b0;
          if (squash) begin
            state_nxt = ST_REQ;
          end else begin
            state_nxt              = ST_READY;
            data_rdy_nxt           = 1'b1;
            if_reg_nxt.pc          = pc;
            if_reg_nxt.instruction = imem_resp_data;
          end
        end
      end

      ST_READY: begin
        if (redirect_valid) begin
          pc_nxt       = redirect_tgt;
          data_rdy_nxt = 1'b0;
          state_nxt    = ST_REQ;
        end else if (id_valid) begin
          pc_nxt       = inc_pc(pc);
          data_rdy_nxt = 1'b0;
          state_nxt    = ST_REQ;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign imem_req_valid = (state == ST_REQ);
  assign imem_req_addr  = imem_req_valid ? pc : '0;
  assign if_data_ready  = data_rdy;
  assign if_pc          = if_reg.pc;
  assign if_instruction = if_reg.instruction;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances (RESET_PC 0 and top-of-memory) share one stimulus stream.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  logic        a_req_valid, b_req_valid;
  logic [63:0] a_req_addr, b_req_addr;
  logic        a_rdy, b_rdy;
  logic [63:0] a_pc, b_pc;
  logic [31:0] a_instr, b_instr;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  fetch_stage #(.RESET_PC(64'h0)) dut_a (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .imem_req_valid (a_req_valid),
    .imem_req_addr  (a_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_data_ready  (a_rdy),
    .if_pc          (a_pc),
    .if_instruction (a_instr)
  );

  fetch_stage #(.RESET_PC(TOP_PC)) dut_b (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .imem_req_valid (b_req_valid),
    .imem_req_addr  (b_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_data_ready  (b_rdy),
    .if_pc          (b_pc),
    .if_instruction (b_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'h0;
    id_valid        = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;

    // Reset state
    step();
    step();
    chk("rst_req_valid", 64'(a_req_valid), 64'h0);
    chk("rst_req_addr", a_req_addr, 64'h0);
    chk("rst_rdy", 64'(a_rdy), 64'h0);
    chk("rst_if_pc", a_pc, 64'h0);
    chk("rst_if_instr", 64'(a_instr), 64'h0);

    // IDLE -> REQ, first request at RESET_PC
    reset = 1'b0;
    step();
    chk("first_req_valid", 64'(a_req_valid), 64'h1);
    chk("first_req_addr", a_req_addr, 64'h0);
    chk("b_first_req_addr", b_req_addr, TOP_PC);

    // Accept, then respond one cycle later
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("wait_req_valid", 64'(a_req_valid), 64'h0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0050_0093;
    chk("rdy_low_in_resp_cycle", 64'(a_rdy), 64'h0);
    step();
    imem_resp_valid = 1'b0;
    chk("cap_rdy", 64'(a_rdy), 64'h1);
    chk("cap_if_pc", a_pc, 64'h0);
    chk("cap_if_instr", 64'(a_instr), 64'h0050_0093);
    chk("b_cap_if_pc", b_pc, TOP_PC);

    // Hold in READY without a push
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_rdy", 64'(a_rdy), 64'h1);
      chk("hold_if_pc", a_pc, 64'h0);
      chk("hold_if_instr", 64'(a_instr), 64'h0050_0093);
      chk("hold_no_req", 64'(a_req_valid), 64'h0);
    end

    // Push: next sequential address, and wrap on the top-of-memory instance
    id_valid = 1'b1;
    step();
    id_valid = 1'b0;
    chk("push_rdy_clr", 64'(a_rdy), 64'h0);
    chk("push_req_valid", 64'(a_req_valid), 64'h1);
    chk("push_req_addr", a_req_addr, 64'h4);
    chk("b_wrap_req_addr", b_req_addr, 64'h0);

    // Redirect while waiting: response squashed, then fetch the aligned target
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1003;
    step();
    redirect_valid = 1'b0;
    chk("squash_wait_no_req", 64'(a_req_valid), 64'h0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    step();
    imem_resp_valid = 1'b0;
    chk("squash_rdy", 64'(a_rdy), 64'h0);
    chk("squash_if_instr", 64'(a_instr), 64'h0050_0093);
    chk("squash_req_valid", 64'(a_req_valid), 64'h1);
    chk("squash_req_addr", a_req_addr, 64'h1000);

    // Fetch at 0x1000
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0013;
    step();
    imem_resp_valid = 1'b0;
    chk("tgt_rdy", 64'(a_rdy), 64'h1);
    chk("tgt_if_pc", a_pc, 64'h1000);
    chk("tgt_if_instr", 64'(a_instr), 64'h0000_0013);

    // Redirect beats a same-cycle push in READY
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    id_valid       = 1'b1;
    step();
    redirect_valid = 1'b0;
    id_valid       = 1'b0;
    chk("rdpush_rdy", 64'(a_rdy), 64'h0);
    chk("rdpush_req_valid", 64'(a_req_valid), 64'h1);
    chk("rdpush_req_addr", a_req_addr, 64'h2000);

    // Redirect and response in the same WAIT cycle
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_pc     = 64'h3000;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1111_1111;
    step();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    chk("samecyc_rdy", 64'(a_rdy), 64'h0);
    chk("samecyc_req_addr", a_req_addr, 64'h3000);

    // Two redirects while squashed: most recent target wins
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h4000;
    step();
    redirect_pc = 64'h5006;
    step();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h2222_2222;
    step();
    imem_resp_valid = 1'b0;
    chk("multi_rdy", 64'(a_rdy), 64'h0);
    chk("multi_req_addr", a_req_addr, 64'h5004);

    // Response outside WAIT is ignored
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h3333_3333;
    step();
    imem_resp_valid = 1'b0;
    chk("stray_rdy", 64'(a_rdy), 64'h0);
    chk("stray_req_addr", a_req_addr, 64'h5004);

    // Redirect in REQ discards the same-cycle acceptance
    redirect_valid = 1'b1;
    redirect_pc    = 64'h6000;
    imem_req_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("reqrd_req_valid", 64'(a_req_valid), 64'h1);
    chk("reqrd_req_addr", a_req_addr, 64'h6000);

    // Reset in WAIT; a response arriving next cycle is ignored
    step();
    imem_req_ready = 1'b0;
    chk("pre_rst_wait", 64'(a_req_valid), 64'h0);
    reset = 1'b1;
    step();
    reset           = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
    step();
    imem_resp_valid = 1'b0;
    chk("post_rst_rdy", 64'(a_rdy), 64'h0);
    chk("post_rst_instr", 64'(a_instr), 64'h0);
    chk("post_rst_req_valid", 64'(a_req_valid), 64'h1);
    chk("post_rst_req_addr", a_req_addr, 64'h0);
    chk("b_post_rst_req_addr", b_req_addr, TOP_PC);

    // Normal fetch resumes after reset
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0010_0073;
    step();
    imem_resp_valid = 1'b0;
    chk("resume_rdy", 64'(a_rdy), 64'h1);
    chk("resume_if_pc", a_pc, 64'h0);
    chk("resume_if_instr", 64'(a_instr), 64'h0010_0073);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be synchronous and active-high.
REQ-004 redirect_valid  in  1  SHALL request a PC redirect (branch/jump) this cycle.
REQ-005 redirect_pc  in  64  SHALL be the redirect target; bits [1:0] SHALL be ignored and treated as 0.
REQ-006 id_valid  in  1  SHALL indicate the IF/ID register accepts data this cycle.
REQ-007 imem_req_valid  out  1  SHALL indicate an instruction-memory read request.
REQ-008 imem_req_addr  out  64  SHALL carry the request address.
REQ-009 imem_req_ready  in  1  SHALL indicate the memory accepts the request this cycle.
REQ-010 imem_resp_valid  in  1  SHALL indicate imem_resp_data is valid this cycle.
REQ-011 imem_resp_data  in  32  SHALL carry the fetched instruction word.
REQ-012 if_data_ready  out  1  SHALL indicate if_pc/if_instruction hold a valid instruction.
REQ-013 if_pc  out  64  SHALL be the address of the presented instruction.
REQ-014 if_instruction  out  32  SHALL be the presented instruction word.

Function
REQ-015 States SHALL be IDLE, REQ, WAIT, READY; at most one memory request outstanding.
REQ-016 IDLE SHALL transition to REQ unconditionally on the next cycle.
REQ-017 In REQ, imem_req_valid SHALL be 1 with imem_req_addr = pc; on imem_req_ready -> WAIT.
REQ-018 In WAIT, on imem_resp_valid: if_instruction <= imem_resp_data, if_pc <= pc, -> READY; if_data_ready SHALL rise the cycle after the response (1-cycle registered latency).
REQ-019 In READY, if_data_ready, if_pc and if_instruction SHALL hold stable until a cycle with id_valid=1 (the push); at that edge pc <= pc+4, if_data_ready <= 0, -> REQ.
REQ-020 pc+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 64'h0).
REQ-021 redirect_valid in IDLE, REQ or READY SHALL set pc <= {redirect_pc[63:2],2'b00}, clear if_data_ready, -> REQ; any same-cycle request acceptance or push SHALL be discarded.
REQ-022 redirect_valid in WAIT SHALL latch the target and set a squash flag; the pending response SHALL be consumed and discarded (no if_data_ready), then -> REQ with the latched target.
REQ-023 Redirect in WAIT in the same cycle as imem_resp_valid SHALL discard that response and go directly to REQ with the new target.
REQ-024 Successive redirects while squashed SHALL keep only the most recent target.
REQ-025 Redirect SHALL have priority over push and over response capture.
REQ-026 imem_resp_valid outside WAIT SHALL be ignored.
REQ-027 imem_req_valid SHALL be 0 in IDLE, WAIT and READY.

Reset
REQ-028 On reset: state=IDLE, pc=RESET_PC, squash flag=0, if_data_ready=0, if_pc=0, if_instruction=0, imem_req_valid=0, imem_req_addr=0.
REQ-029 Reset asserted mid-request or mid-wait SHALL abandon it; the first post-reset response received before re-entering WAIT SHALL be ignored per REQ-026.

Structure
REQ-030 The fetch state enum (fetch_state_t) and the instruction-width and PC-width constants SHALL live in the shared pipeline package with the pipeline register structs.
REQ-031 The block SHALL be a single module; no sub-module.

Verification
REQ-032 Reset, ready=1, resp 1 cycle later with 32'h00500093 -> req addr 0, if_data_ready rises the cycle after resp, if_pc=0, if_instruction=32'h00500093.
REQ-033 id_valid=0 for 5 cycles in READY -> outputs stable, no new request; id_valid=1 -> next request addr 64'h4.
REQ-034 redirect_valid, redirect_pc=64'h1003 in WAIT, then resp 32'hDEADBEEF -> response discarded, next request addr 64'h1000.
REQ-035 Redirect to 64'h2000 in READY while id_valid=1 -> no push counted, if_data_ready=0 next cycle, next request addr 64'h2000.
REQ-036 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, one fetch and push -> next request addr 64'h0.
REQ-037 reset asserted in WAIT, resp arrives 1 cycle later -> ignored; first post-reset request addr = RESET_PC.
